// File: rtl/bit_unstuff.sv
// bit_unstuff: receive-path bit unstuffer.
// Removes the zero inserted after every MAX_ONES consecutive ones. It also flags
// stuffing violations and length overflow, and frames the kept bits for the CRC
// checker and the sipo_register. Output latency is one cycle.
//   clk, rst                        : clock, async active-high reset
//   s_in, start_unstuffer,
//   end_unstuffer                   : decoded serial bit and packet framing
//   s_out, s_valid                  : kept data bit and its qualifier
//   start_crc, end_crc              : packet framing towards the CRC checker
//   stuff_error, overflow           : sticky flags, cleared by the next start
//   bit_count                       : kept bits in the current/last packet
//   busy                            : packet in progress (RUN or STUFF)
module bit_unstuff #(
  parameter int unsigned MAX_ONES = 6,
  parameter int unsigned MAX_BITS = 90,
  parameter int unsigned CW       = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_in,
  input  logic          start_unstuffer,
  input  logic          end_unstuffer,
  output logic          s_out,
  output logic          s_valid,
  output logic          start_crc,
  output logic          end_crc,
  output logic          stuff_error,
  output logic          overflow,
  output logic [CW-1:0] bit_count,
  output logic          busy
);

  localparam int unsigned OW = $clog2(MAX_ONES + 1);

  typedef enum logic [1:0] {IDLE, RUN, STUFF, ERR} state_t;

  state_t        state;
  logic [OW-1:0] ones;
  logic [OW-1:0] base_ones;
  logic [OW-1:0] inc_ones;
  logic [CW-1:0] base_cnt;
  logic          keep;
  logic          run_hit;
  logic          cnt_full;

  // A start bit is always data. It is counted from a cleared run and bit count,
  // so one shared data path serves both RUN and start in any state.
  always_comb begin
    keep      = start_unstuffer || (state == RUN);
    base_ones = start_unstuffer ? '0 : ones;
    base_cnt  = start_unstuffer ? '0 : bit_count;
    inc_ones  = s_in ? (base_ones + OW'(1)) : '0;
    run_hit   = (inc_ones == OW'(MAX_ONES));
    cnt_full  = (base_cnt == CW'(MAX_BITS));
  end

  assign busy = (state == RUN) || (state == STUFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ones        <= '0;
      s_out       <= 1'b0;
      s_valid     <= 1'b0;
      start_crc   <= 1'b0;
      end_crc     <= 1'b0;
      stuff_error <= 1'b0;
      overflow    <= 1'b0;
      bit_count   <= '0;
    end else begin
      s_valid   <= 1'b0;
      start_crc <= 1'b0;
      end_crc   <= 1'b0;

      if (keep) begin
        s_out     <= s_in;
        s_valid   <= 1'b1;
        start_crc <= start_unstuffer;
        if (start_unstuffer) begin
          stuff_error <= 1'b0;
          overflow    <= 1'b0;
        end
        if (cnt_full) begin
          bit_count <= CW'(MAX_BITS);
          overflow  <= 1'b1;
        end else begin
          bit_count <= base_cnt + CW'(1);
        end
        ones <= run_hit ? '0 : inc_ones;
        if (end_unstuffer) begin
          // The mandatory stuffed zero can never arrive: report it now.
          end_crc <= 1'b1;
          state   <= IDLE;
          if (run_hit) stuff_error <= 1'b1;
        end else begin
          state <= run_hit ? STUFF : RUN;
        end
      end else begin
        case (state)
          STUFF: begin
            if (s_in) stuff_error <= 1'b1;
            if (end_unstuffer) begin
              end_crc <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= s_in ? ERR : RUN;
            end
          end
          ERR: begin
            if (end_unstuffer) begin
              end_crc <= 1'b1;
              state   <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_unstuff.sv
module tb_bit_unstuff;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_in;
  logic       start_unstuffer;
  logic       end_unstuffer;
  logic       s_out;
  logic       s_valid;
  logic       start_crc;
  logic       end_crc;
  logic       stuff_error;
  logic       overflow;
  logic [6:0] bit_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model of the packet being received.
  int m_kept;      // data bits kept so far
  int m_run;       // length of the current run of kept ones
  bit m_expect0;   // the next bit must be the inserted zero
  bit m_dead;      // violation seen, nothing more is kept
  bit m_err;
  bit m_ovf;
  bit m_last_out;

  bit_unstuff #(.MAX_ONES(6), .MAX_BITS(90)) dut (
    .clk(clk), .rst(rst), .s_in(s_in),
    .start_unstuffer(start_unstuffer), .end_unstuffer(end_unstuffer),
    .s_out(s_out), .s_valid(s_valid), .start_crc(start_crc), .end_crc(end_crc),
    .stuff_error(stuff_error), .overflow(overflow), .bit_count(bit_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] actual_status();
    return {s_valid, s_out, start_crc, end_crc, stuff_error, overflow, busy, bit_count};
  endfunction

  task automatic model_clear();
    m_kept = 0; m_run = 0; m_expect0 = 0; m_dead = 0;
    m_err = 0; m_ovf = 0; m_last_out = 0;
  endtask

  // Sends one packet, starting on bits[0] and, if do_end, ending on the last bit.
  // Each bit's output cycle is checked against the model.
  task automatic send_packet(input bit bits[$], input bit do_end, input string name);
    bit first, last, v;
    logic [13:0] exp, act;
    int cnt;
    for (int i = 0; i < bits.size(); i++) begin
      first = (i == 0);
      last  = do_end && (i == bits.size() - 1);
      s_in = bits[i]; start_unstuffer = first; end_unstuffer = last;
      if (first) begin
        m_kept = 0; m_run = 0; m_expect0 = 0; m_dead = 0; m_err = 0; m_ovf = 0;
      end
      v = 0;
      if (m_dead) begin
      end else if (m_expect0) begin
        m_expect0 = 0;
        if (bits[i]) begin m_err = 1; m_dead = 1; end
      end else begin
        v = 1; m_last_out = bits[i]; m_kept++;
        if (m_kept > 90) m_ovf = 1;
        m_run = bits[i] ? m_run + 1 : 0;
        if (m_run == 6) begin
          m_run = 0; m_expect0 = 1;
          if (last) m_err = 1;
        end
      end
      cnt = (m_kept > 90) ? 90 : m_kept;
      exp = {v, m_last_out, first, last, m_err, m_ovf, !last && !m_dead, 7'(cnt)};
      @(posedge clk); #1;
      act = actual_status();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s bit %0d: got %b expected %b (v,out,sc,ec,err,ovf,busy,cnt)",
                 name, i, act, exp);
      end
    end
    start_unstuffer = 0; end_unstuffer = 0;
  endtask

  task automatic test_idle(input int cycles);
    logic [13:0] exp, act;
    for (int i = 0; i < cycles; i++) begin
      s_in = 1'($urandom);
      exp = {1'b0, m_last_out, 1'b0, 1'b0, m_err, m_ovf, 1'b0,
             7'((m_kept > 90) ? 90 : m_kept)};
      @(posedge clk); #1;
      act = actual_status();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL idle cycle %0d: got %b expected %b", i, act, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; s_in = 0; start_unstuffer = 0; end_unstuffer = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (actual_status() !== 14'b0) begin
      errors++;
      $display("FAIL reset: got %b expected %b", actual_status(), 14'b0);
    end
    rst = 0;
    test_idle(2);
  endtask

  task automatic test_plain();
    bit q[$] = '{1,1,0,0,0,0,1,1};
    send_packet(q, 1, "plain");
    test_idle(2);
  endtask

  task automatic test_stuffed();
    bit q[$] = '{1,1,1,1,1,1,0,1,0,1};
    send_packet(q, 1, "stuffed");
    test_idle(1);
  endtask

  task automatic test_violation();
    bit q[$] = '{1,1,1,1,1,1,1,1};
    send_packet(q, 1, "violation");
    test_idle(1);
  endtask

  task automatic test_end_boundaries();
    bit q6[$] = '{0,1,1,1,1,1,1};
    bit q7[$] = '{1,1,1,1,1,1,0};
    bit q1[$] = '{1};
    send_packet(q6, 1, "end_on_sixth_one");
    test_idle(1);
    send_packet(q7, 1, "end_on_stuff_zero");
    test_idle(1);
    send_packet(q1, 1, "single_bit");
    test_idle(1);
  endtask

  task automatic test_overflow();
    bit q[$];
    bit c[$] = '{0,1,1,0};
    for (int i = 0; i < 91; i++) q.push_back((i % 5 == 4) ? 1'b0 : 1'($urandom));
    send_packet(q, 1, "overflow");
    test_idle(1);
    send_packet(c, 1, "clear_after_overflow");
    test_idle(1);
  endtask

  task automatic test_abort();
    bit a[$] = '{1,1,1,1,1,1};
    bit b[$] = '{1,0,1,1,0};
    send_packet(a, 0, "aborted_in_stuff");
    send_packet(b, 1, "restart_after_abort");
    test_idle(1);
  endtask

  task automatic test_reset_mid();
    bit a[$] = '{1,0,1,1,0};
    bit b[$] = '{0,1,1,1,0,1};
    send_packet(a, 0, "before_reset");
    rst = 1;
    #1;
    checks++;
    if (actual_status() !== 14'b0) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", actual_status(), 14'b0);
    end
    model_clear();
    @(posedge clk); #1;
    checks++;
    if (actual_status() !== 14'b0) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", actual_status(), 14'b0);
    end
    rst = 0;
    test_idle(1);
    send_packet(b, 1, "after_reset");
    test_idle(1);
  endtask

  task automatic test_random();
    bit q[$];
    for (int p = 0; p < 12; p++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 30)); i++)
        q.push_back($urandom_range(0, 9) < 8);
      send_packet(q, 1, "random");
      test_idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_stuffed();
    test_violation();
    test_end_boundaries();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
